// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                              |
// | Description : Round-robin burst scheduler for the async FIFO write port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [15:0]                   stall_cnt
);

  localparam int           c_IDX_W    = $clog2(NUM_REQ);
  localparam logic [0:0]   c_IDLE     = 1'b0;
  localparam logic [0:0]   c_GRANT    = 1'b1;
  localparam logic [7:0]   c_BEAT_MAX = 8'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [c_IDX_W-1:0] r_owner;
  logic [c_IDX_W-1:0] r_last_owner;
  logic [7:0]         r_beat;
  logic [15:0]        r_stall_cnt;

  logic               w_found;
  logic [c_IDX_W-1:0] w_winner;
  logic               w_accept;
  logic               w_release;

  // Round-robin scan starts just after the previous owner and wraps.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[(i + int'(r_last_owner) + 1) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = c_IDX_W'((i + int'(r_last_owner) + 1) % NUM_REQ);
      end
    end
  end

  assign w_accept  = (r_state == c_GRANT) & req[r_owner] & ~wfull;
  // A wfull stall alone never releases; abandoning (req low) does.
  assign w_release = (r_state == c_GRANT) &
                     ((w_accept & (req_last[r_owner] | (r_beat == c_BEAT_MAX))) |
                      ~req[r_owner]);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_found)   w_state_nxt = c_GRANT;
      c_GRANT: if (w_release) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_gnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= c_IDX_W'(NUM_REQ - 1);
      r_beat       <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if ((r_state == c_IDLE) && w_found) begin
        r_gnt   <= c_ONE << w_winner;
        r_owner <= w_winner;
        r_beat  <= '0;
      end else if (w_release) begin
        r_gnt        <= '0;
        r_last_owner <= r_owner;
      end
      if (w_accept) begin
        r_beat <= r_beat + 8'd1;
      end
      if ((r_state == c_GRANT) && req[r_owner] && wfull && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  // Reset masks the write strobe even while the state register still says GRANT.
  always_comb begin
    winc  = 1'b0;
    ack   = '0;
    wdata = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    if (w_accept && !wrst) begin
      winc         = 1'b1;
      ack[r_owner] = 1'b1;
    end
  end

  assign gnt       = r_gnt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_wr_arbiter                                           |
// | Description : Vector table plus write scoreboard for fifo_wr_arbiter.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        wfull;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        winc;
  logic [7:0]  wdata;
  logic [15:0] stall_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic [15:0] stall;
  } vec_t;

  vec_t       tbl[$];
  logic [11:0] sb[$];   // expected {ack, wdata} per FIFO write

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
    .wfull(wfull), .gnt(gnt), .ack(ack), .winc(winc), .wdata(wdata),
    .stall_cnt(stall_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l,
                              input logic wf, input logic [3:0] g, input logic wi,
                              input logic [7:0] wd, input logic [15:0] st);
    vec_t v;
    v.req = r; v.data = d; v.last = l; v.wfull = wf;
    v.gnt = g; v.winc = wi; v.wdata = wd; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1; req = '0; req_last = '0; wfull = 1'b0; req_data = '0;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  // Every FIFO write is matched against the oldest expected word.
  always @(negedge wclk) begin
    if (winc === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: got ack=%b wdata=%h expected no write", ack, wdata);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if ({ack, wdata} !== e) begin
          n_fail++;
          $display("FAIL sb_write: got ack=%b wdata=%h expected ack=%b wdata=%h",
                   ack, wdata, e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   idx;
    int   grants;
    int   wpg[$];
    logic prev;

    // single requester 2, 3-word burst
    tbl.push_back(mk(4'b0100, 32'h00A0_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 16'd0));
    tbl.push_back(mk(4'b0100, 32'h00A0_0000, 4'b0000, 0, 4'b0100, 1, 8'hA0, 16'd0));
    tbl.push_back(mk(4'b0100, 32'h00A1_0000, 4'b0000, 0, 4'b0100, 1, 8'hA1, 16'd0));
    tbl.push_back(mk(4'b0100, 32'h00A2_0000, 4'b0100, 0, 4'b0100, 1, 8'hA2, 16'd0));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 16'd0));
    // owner 0 stalled by wfull for 5 cycles mid-burst
    tbl.push_back(mk(4'b0001, 32'h0000_00B0, 4'b0000, 0, 4'b0000, 0, 8'h00, 16'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_00B0, 4'b0000, 0, 4'b0001, 1, 8'hB0, 16'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 1, 4'b0001, 0, 8'h00, 16'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 1, 4'b0001, 0, 8'h00, 16'd1));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 1, 4'b0001, 0, 8'h00, 16'd2));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 1, 4'b0001, 0, 8'h00, 16'd3));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 1, 4'b0001, 0, 8'h00, 16'd4));
    tbl.push_back(mk(4'b0001, 32'h0000_00B1, 4'b0000, 0, 4'b0001, 1, 8'hB1, 16'd5));
    tbl.push_back(mk(4'b0001, 32'h0000_00B2, 4'b0001, 0, 4'b0001, 1, 8'hB2, 16'd5));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 16'd5));
    // owner 1 abandons after one word; requester 2 then served
    tbl.push_back(mk(4'b0110, 32'h00D0_C000, 4'b0100, 0, 4'b0000, 0, 8'h00, 16'd5));
    tbl.push_back(mk(4'b0110, 32'h00D0_C000, 4'b0100, 0, 4'b0010, 1, 8'hC0, 16'd5));
    tbl.push_back(mk(4'b0100, 32'h00D0_C100, 4'b0100, 0, 4'b0010, 0, 8'h00, 16'd5));
    tbl.push_back(mk(4'b0100, 32'h00D0_C100, 4'b0100, 0, 4'b0000, 0, 8'h00, 16'd5));
    tbl.push_back(mk(4'b0100, 32'h00D0_C100, 4'b0100, 0, 4'b0100, 1, 8'hD0, 16'd5));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 16'd5));

    // reset state
    wrst = 1'b1; req = '0; req_last = '0; wfull = 1'b0; req_data = '0;
    repeat (3) tick();
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    tick();
    wrst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      req = v.req; req_data = v.data; req_last = v.last; wfull = v.wfull;
      if (v.winc) sb.push_back({v.gnt, v.wdata});
      #3;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(v.gnt));
      chk($sformatf("vec%0d_winc", i), 32'(winc), 32'(v.winc));
      chk($sformatf("vec%0d_ack", i), 32'(ack), v.winc ? 32'(v.gnt) : 32'h0);
      chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(v.stall));
      tick();
    end

    // reset asserted while requester 3 holds the grant
    req = 4'b1001; req_data = 32'hE000_00F0; req_last = '0; wfull = 1'b0;
    #3;
    chk("mrst_idle_gnt", 32'(gnt), 32'h0);
    tick();
    wrst = 1'b1;
    #3;
    chk("mrst_gnt_held", 32'(gnt), 32'h8);
    chk("mrst_winc_masked", 32'(winc), 32'h0);
    chk("mrst_ack_masked", 32'(ack), 32'h0);
    tick();
    wrst = 1'b0;
    #3;
    chk("mrst_gnt_cleared", 32'(gnt), 32'h0);
    chk("mrst_stall_cleared", 32'(stall_cnt), 32'h0);
    chk("mrst_winc", 32'(winc), 32'h0);
    tick();
    sb.push_back({4'b0001, 8'hF0});
    #3;
    chk("mrst_req0_wins", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    tick();

    // round robin, single-word bursts from all requesters
    do_reset();
    req = 4'b1111; req_last = 4'b1111; req_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) sb.push_back({4'(4'b0001 << (k % 4)), 8'(8'h10 + (k % 4))});
    for (int k = 0; k < 10; k++) begin
      #3;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), (k % 2) ? 32'(4'b0001 << ((k / 2) % 4)) : 32'h0);
      tick();
    end
    req = '0;
    tick();
    tick();

    // burst cap: requester 1 streams 20 words without req_last
    do_reset();
    for (int k = 0; k < 20; k++) sb.push_back({4'b0010, 8'(8'h40 + k)});
    idx = 0; grants = 0; prev = 1'b0;
    for (int c = 0; c < 100 && !(idx == 20 && gnt == 4'b0000); c++) begin
      req      = (idx < 20) ? 4'b0010 : 4'b0000;
      req_data = {16'h0000, 8'(8'h40 + idx), 8'h00};
      req_last = '0;
      wfull    = 1'b0;
      #3;
      if (gnt[1] && !prev) begin
        grants++;
        wpg.push_back(0);
      end
      prev = gnt[1];
      if (ack[1] && wpg.size() > 0) begin
        idx++;
        wpg[wpg.size()-1] += 1;
      end
      tick();
    end
    req = '0;
    chk("burst_words", 32'(idx), 32'd20);
    chk("burst_grants", 32'(grants), 32'd3);
    for (int g = 0; g < 3; g++)
      chk($sformatf("burst_len%0d", g), (g < wpg.size()) ? 32'(wpg[g]) : 32'hFFFF_FFFF,
          (g < 2) ? 32'd8 : 32'd4);
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
